// File: rtl/serial_bus_master_pkg.sv
// Shared types and constants for the single-bit serial bus (master and 2K slave).
package serial_bus_pkg;

    localparam int unsigned ADDR_BITS = 16;
    localparam int unsigned DATA_BITS = 8;

    // Direction encoding carried on b_rw; the slave decodes the same values.
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        WAIT_ACK_A,
        ACK_A_HI,
        DATA_WR,
        WAIT_ACK_W,
        ACK_W_HI,
        DATA_RD,
        DONE,
        ABORT
    } master_state_e;

    // Width of a counter that must reach max(bits, timeout) without wrapping.
    function automatic int unsigned cnt_width(input int unsigned bits,
                                              input int unsigned timeout);
        int unsigned top;
        top = (bits > timeout) ? bits : timeout;
        return $clog2(top + 1);
    endfunction

endpackage

// File: rtl/serial_bus_master_if.sv
// User-side request/response and serial bus signals of the bus master.
interface serial_bus_master_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              m_start;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_busy;
    logic              m_dvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              m_err;
    logic              b_util;
    logic              b_rw;
    logic              b_bus_out;
    logic              b_bus_in;
    logic              b_ack;
    logic              b_sbsy;

    modport master (
        input  m_start, m_rw, m_addr, m_wdata, b_bus_in, b_ack, b_sbsy,
        output m_busy, m_dvalid, m_rdata, m_err, b_util, b_rw, b_bus_out
    );

    modport slave (
        output m_start, m_rw, m_addr, m_wdata, b_bus_in, b_ack, b_sbsy,
        input  m_busy, m_dvalid, m_rdata, m_err, b_util, b_rw, b_bus_out
    );
endinterface

// File: rtl/serial_bus_master_counter.sv
// Phase bit / ack-timeout counter with synchronous clear and increment.
module serial_bus_master_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rst,
    input  logic         incr,
    output logic [W-1:0] count
);

    // Clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (rst) begin
            count <= '0;
        end else if (incr) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/serial_bus_master.sv
// Initiator of the single-bit serial bus: serialises one read/write request,
// handles the two slave ack handshakes and returns read data.
module serial_bus_master
    import serial_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_BITS,
    parameter int unsigned DATA_W      = DATA_BITS,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_bus_master_if.master bus
);

    localparam int unsigned CNT_W = cnt_width(ADDR_W, ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

    master_state_e     state;
    master_state_e     state_n;

    logic [CNT_W-1:0]  cnt;
    logic              cnt_clr;
    logic              cnt_incr;

    logic              rw_q;
    logic              rw_n;
    logic [ADDR_W-1:0] addr_sr;
    logic [ADDR_W-1:0] addr_sr_n;
    logic [DATA_W-1:0] wd_sr;
    logic [DATA_W-1:0] wd_sr_n;
    logic [DATA_W-1:0] rd_sr;
    logic [DATA_W-1:0] rd_sr_n;

    logic              busy_q;
    logic              dvalid_q;
    logic              err_q;
    logic              util_q;
    logic              rw_out_q;
    logic              bus_out_q;
    logic [DATA_W-1:0] rdata_q;

    logic              busy_d;
    logic              dvalid_d;
    logic              err_d;
    logic              util_d;
    logic              rw_out_d;
    logic              bus_out_d;
    logic [DATA_W-1:0] rdata_d;

    // Slave busy is observed on the bus but does not steer the master.
    logic              unused_sbsy;
    assign unused_sbsy = bus.b_sbsy;

    serial_bus_master_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .rst   (cnt_clr),
        .incr  (cnt_incr),
        .count (cnt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, counter control, shift registers and the next serial bit.
    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        cnt_incr  = 1'b0;
        rw_n      = rw_q;
        addr_sr_n = addr_sr;
        wd_sr_n   = wd_sr;
        rd_sr_n   = rd_sr;
        bus_out_d = 1'b0;
        rdata_d   = rdata_q;

        unique case (state)
            IDLE: begin
                if (bus.m_start) begin
                    state_n   = ADDR;
                    cnt_clr   = 1'b1;
                    rw_n      = bus.m_rw;
                    addr_sr_n = bus.m_addr;
                    wd_sr_n   = bus.m_wdata;
                    rd_sr_n   = '0;
                    bus_out_d = bus.m_addr[0];
                end
            end
            ADDR: begin
                if (cnt == ADDR_LAST) begin
                    state_n = WAIT_ACK_A;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_incr  = 1'b1;
                    addr_sr_n = addr_sr >> 1;
                    bus_out_d = addr_sr[1];
                end
            end
            WAIT_ACK_A, WAIT_ACK_W: begin
                if (bus.b_ack) begin
                    state_n = (state == WAIT_ACK_A) ? ACK_A_HI : ACK_W_HI;
                    cnt_clr = 1'b1;
                end else if (cnt == ACK_LAST) begin
                    state_n = ABORT;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_incr = 1'b1;
                end
            end
            ACK_A_HI: begin
                cnt_clr = 1'b1;
                if (!bus.b_ack) begin
                    if (rw_q == RW_WRITE) begin
                        state_n   = DATA_WR;
                        bus_out_d = wd_sr[0];
                    end else begin
                        state_n = DATA_RD;
                    end
                end
            end
            DATA_WR: begin
                if (cnt == DATA_LAST) begin
                    state_n = WAIT_ACK_W;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_incr  = 1'b1;
                    wd_sr_n   = wd_sr >> 1;
                    bus_out_d = wd_sr[1];
                end
            end
            ACK_W_HI: begin
                cnt_clr = 1'b1;
                if (!bus.b_ack) begin
                    state_n = DONE;
                end
            end
            DATA_RD: begin
                // Bits arrive LSB first, so shift in from the top.
                rd_sr_n = {bus.b_bus_in, rd_sr[DATA_W-1:1]};
                if (cnt == DATA_LAST) begin
                    state_n = DONE;
                    cnt_clr = 1'b1;
                    rdata_d = {bus.b_bus_in, rd_sr[DATA_W-1:1]};
                end else begin
                    cnt_incr = 1'b1;
                end
            end
            DONE, ABORT: begin
                state_n = IDLE;
                cnt_clr = 1'b1;
            end
            default: begin
                state_n = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Status outputs follow the state being entered so they line up with it.
    always_comb begin
        busy_d   = (state_n != IDLE);
        util_d   = (state_n != IDLE) && (state_n != ABORT);
        dvalid_d = (state_n == DONE);
        err_d    = (state_n == ABORT);
        rw_out_d = util_d && rw_n;
    end

    // Request latches and shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q    <= 1'b0;
            addr_sr <= '0;
            wd_sr   <= '0;
            rd_sr   <= '0;
        end else begin
            rw_q    <= rw_n;
            addr_sr <= addr_sr_n;
            wd_sr   <= wd_sr_n;
            rd_sr   <= rd_sr_n;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            dvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            util_q    <= 1'b0;
            rw_out_q  <= 1'b0;
            bus_out_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            busy_q    <= busy_d;
            dvalid_q  <= dvalid_d;
            err_q     <= err_d;
            util_q    <= util_d;
            rw_out_q  <= rw_out_d;
            bus_out_q <= bus_out_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.m_busy    = busy_q;
    assign bus.m_dvalid  = dvalid_q;
    assign bus.m_err     = err_q;
    assign bus.b_util    = util_q;
    assign bus.b_rw      = rw_out_q;
    assign bus.b_bus_out = bus_out_q;
    assign bus.m_rdata   = rdata_q;

endmodule

// File: tb/tb_serial_bus_master.sv
// Bench for serial_bus_master: per-transaction expected waveforms are built
// from the bus protocol rules and compared against the DUT every cycle.
module tb_serial_bus_master;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ACK_TIMEOUT = 8;

    typedef struct {
        bit       busy;
        bit       dvalid;
        bit       err;
        bit       util;
        bit       rw;
        bit       bo;
        bit [7:0] rdata;
    } exp_t;

    typedef struct {
        bit        start;
        bit        rw;
        bit        ack;
        bit        bin;
        bit        sbsy;
        bit [15:0] addr;
        bit [7:0]  wdata;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    serial_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    serial_bus_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t     exp_q[$];
    stim_t    stim_q[$];
    exp_t     cur_exp;
    bit       exp_en = 1'b0;
    int       cyc_idx = 0;
    int       checks = 0;
    int       errors = 0;
    bit [7:0] mem [0:2047];
    bit [7:0] model_rdata = 8'h00;
    bit       force_start = 1'b0;
    bit       bo_log [0:127];
    int       dv_count = 0;
    int       err_count = 0;
    int       dv_idx = -1;
    int       err_idx = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc_idx, act, req);
        end
    endtask

    // Per-cycle comparison against the expected record for this cycle.
    always @(negedge clk) begin
        if (exp_en) begin
            chk("m_busy",    32'(bus.m_busy),    32'(cur_exp.busy));
            chk("m_dvalid",  32'(bus.m_dvalid),  32'(cur_exp.dvalid));
            chk("m_err",     32'(bus.m_err),     32'(cur_exp.err));
            chk("b_util",    32'(bus.b_util),    32'(cur_exp.util));
            chk("b_rw",      32'(bus.b_rw),      32'(cur_exp.rw));
            chk("b_bus_out", 32'(bus.b_bus_out), 32'(cur_exp.bo));
            chk("m_rdata",   32'(bus.m_rdata),   32'(cur_exp.rdata));
            if (cyc_idx < 128) bo_log[cyc_idx] = bus.b_bus_out;
            if (bus.m_dvalid === 1'b1) begin dv_count++; dv_idx = cyc_idx; end
            if (bus.m_err === 1'b1) begin err_count++; err_idx = cyc_idx; end
        end
    end

    function automatic stim_t rnd_stim(input bit allow_start);
        stim_t s;
        s.start = allow_start ? (force_start ? 1'b1 : 1'($urandom)) : 1'b0;
        s.rw    = 1'($urandom);
        s.addr  = 16'($urandom);
        s.wdata = 8'($urandom);
        s.ack   = 1'b0;
        s.bin   = 1'($urandom);
        s.sbsy  = 1'($urandom);
        return s;
    endfunction

    function automatic exp_t mk(input bit busy, input bit dv, input bit err,
                                input bit util, input bit rw, input bit bo);
        exp_t e;
        e.busy = busy; e.dvalid = dv; e.err = err;
        e.util = util; e.rw = rw; e.bo = bo; e.rdata = model_rdata;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        bus.m_start  = s.start;
        bus.m_rw     = s.rw;
        bus.m_addr   = s.addr;
        bus.m_wdata  = s.wdata;
        bus.b_ack    = s.ack;
        bus.b_bus_in = s.bin;
        bus.b_sbsy   = s.sbsy;
    endtask

    task automatic drive_queue(input int stop_at);
        int n;
        n = exp_q.size();
        if (stop_at >= 0 && stop_at < n) n = stop_at;
        dv_count = 0; err_count = 0; dv_idx = -1; err_idx = -1;
        for (int c = 0; c < n; c++) begin
            apply(stim_q[c]);
            cur_exp = exp_q[c];
            cyc_idx = c;
            exp_en  = 1'b1;
            @(posedge clk);
            #1;
        end
        exp_en = 1'b0;
    endtask

    // Ack handshake: silent for da cycles, ack held for ha cycles, one low cycle.
    // A slave that stays silent for ACK_TIMEOUT cycles earns a one-cycle abort.
    task automatic ack_phase(input bit rw, input int da, input int ha, output bit ok);
        stim_t s;
        if (da >= int'(ACK_TIMEOUT)) begin
            for (int i = 0; i < int'(ACK_TIMEOUT); i++) begin
                s = rnd_stim(1); stim_q.push_back(s); exp_q.push_back(mk(1, 0, 0, 1, rw, 0));
            end
            s = rnd_stim(1); stim_q.push_back(s); exp_q.push_back(mk(1, 0, 1, 0, 0, 0));
            ok = 1'b0;
        end else begin
            for (int i = 0; i < da + ha + 1; i++) begin
                s = rnd_stim(1);
                s.ack = (i >= da) && (i < da + ha);
                stim_q.push_back(s); exp_q.push_back(mk(1, 0, 0, 1, rw, 0));
            end
            ok = 1'b1;
        end
    endtask

    task automatic run_txn(input bit rw, input bit [15:0] addr, input bit [7:0] wd,
                           input int da, input int ha, input int dw, input int hw,
                           input int stop_at);
        stim_t    s;
        bit       ok;
        bit [7:0] rbyte;
        exp_q.delete(); stim_q.delete();
        s = rnd_stim(0);
        s.start = 1'b1; s.rw = rw; s.addr = addr; s.wdata = wd; s.ack = 1'($urandom);
        stim_q.push_back(s); exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++) begin
            s = rnd_stim(1); stim_q.push_back(s); exp_q.push_back(mk(1, 0, 0, 1, rw, addr[i]));
        end
        ack_phase(rw, da, ha, ok);
        if (ok) begin
            rbyte = mem[addr[12:2]];
            for (int i = 0; i < 8; i++) begin
                s = rnd_stim(1);
                s.ack = 1'($urandom);
                if (!rw) s.bin = rbyte[i];
                stim_q.push_back(s); exp_q.push_back(mk(1, 0, 0, 1, rw, rw ? wd[i] : 1'b0));
            end
            if (rw) ack_phase(rw, dw, hw, ok);
            if (ok) begin
                if (stop_at < 0) begin
                    if (rw) mem[addr[12:2]] = wd;
                    else model_rdata = rbyte;
                end
                s = rnd_stim(1); s.ack = 1'($urandom);
                stim_q.push_back(s); exp_q.push_back(mk(1, 1, 0, 1, rw, 0));
            end
        end
        drive_queue(stop_at);
    endtask

    task automatic idle(input int n);
        stim_t s;
        exp_q.delete(); stim_q.delete();
        for (int i = 0; i < n; i++) begin
            s = rnd_stim(0); s.ack = 1'($urandom);
            stim_q.push_back(s); exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        end
        drive_queue(-1);
    endtask

    function automatic bit [15:0] grab(input int base, input int nbits);
        bit [15:0] v;
        v = '0;
        for (int i = 0; i < nbits; i++) v[i] = bo_log[base + i];
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " m_busy"},    32'(bus.m_busy),    32'h0);
        chk({tag, " m_dvalid"},  32'(bus.m_dvalid),  32'h0);
        chk({tag, " m_err"},     32'(bus.m_err),     32'h0);
        chk({tag, " b_util"},    32'(bus.b_util),    32'h0);
        chk({tag, " b_rw"},      32'(bus.b_rw),      32'h0);
        chk({tag, " b_bus_out"}, 32'(bus.b_bus_out), 32'h0);
        chk({tag, " m_rdata"},   32'(bus.m_rdata),   32'h0);
    endtask

    initial begin
        bit [15:0] a;
        int        da;
        int        dw;
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        apply(rnd_stim(0));
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_all_zero("reset");
        idle(2);

        // Directed write of A5 to address 4.
        run_txn(1'b1, 16'h0004, 8'hA5, 0, 1, 0, 1, -1);
        chk("wr addr stream", 32'(grab(1, 16)), 32'h0004);
        chk("wr data stream", 32'(grab(19, 8)), 32'h00A5);
        chk("wr dvalid count", 32'(dv_count), 32'd1);
        chk("wr dvalid cycle", 32'(dv_idx), 32'd29);
        idle(1);

        // Read it back.
        run_txn(1'b0, 16'h0004, 8'h00, 0, 1, 0, 0, -1);
        chk("rd rdata", 32'(bus.m_rdata), 32'h00A5);
        chk("rd dvalid count", 32'(dv_count), 32'd1);
        chk("rd dvalid cycle", 32'(dv_idx), 32'd27);
        chk("rd util after", 32'(bus.b_util), 32'h0);

        // Silent slave: abort after ACK_TIMEOUT wait cycles.
        run_txn(1'b1, 16'h0008, 8'h5A, 20, 1, 0, 1, -1);
        chk("to err count", 32'(err_count), 32'd1);
        chk("to err cycle", 32'(err_idx), 32'd25);
        chk("to dvalid count", 32'(dv_count), 32'd0);

        // Long ack: data phase begins right after ack falls.
        run_txn(1'b1, 16'h0010, 8'h3C, 1, 5, 0, 1, -1);
        chk("ext data stream", 32'(grab(24, 8)), 32'h003C);
        chk("ext dvalid count", 32'(dv_count), 32'd1);

        // Request during busy, then reset in the middle of the address phase.
        force_start = 1'b1;
        run_txn(1'b1, 16'h1234, 8'h77, 0, 1, 0, 1, 6);
        force_start = 1'b0;
        chk("pre-reset util", 32'(bus.b_util), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_rdata = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        run_txn(1'b1, 16'h0020, 8'hC3, 2, 2, 1, 3, -1);
        chk("post-reset data", 32'(grab(1 + 16 + 5, 8)), 32'h00C3);
        chk("post-reset dvalid", 32'(dv_count), 32'd1);

        // Randomised traffic over a handful of words so reads hit prior writes.
        for (int t = 0; t < 40; t++) begin
            a = 16'($urandom);
            a[12:2] = 11'($urandom_range(0, 7));
            da = ($urandom_range(0, 9) == 0) ? 8 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 7));
            dw = ($urandom_range(0, 9) == 0) ? 8 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 7));
            run_txn(1'($urandom), a, 8'($urandom), da, int'($urandom_range(1, 4)),
                    dw, int'($urandom_range(1, 4)), -1);
            idle(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
